video_timing_monitor: RTL and testbench

VIDEO_TIMING_MONITOR -- requirements
Module: video_timing_monitor

---
 rtl/video_timing_monitor.sv | 273 +++++++++++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_monitor.sv
`timescale 1ns/1ps
// video_timing_monitor
//
// Purpose: measures the timing of a raster video stream (hs/vs/vld/rgb) and
// publishes, once per frame, the line period, active pixels per line, lines
// per frame, active lines per frame and a 32-bit pixel checksum. It also
// reports when two consecutive published sets are identical (locked) and
// raises a sticky error on inconsistent active-line lengths or on pixels
// qualified during an hs edge.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   hs, vs     horizontal / vertical sync (rising edge is the event)
//   vld        active-pixel qualifier
//   rgb        pixel data (3*PW bits), meaningful when vld=1
//   h_total    clocks per line (last valid line period of the frame)
//   h_act      vld clocks of the last active line of the frame
//   v_total    hs edges per frame
//   v_act      active lines per frame
//   frame_sum  sum of rgb (zero-extended) over all vld cycles, mod 2^32
//   meas_vld   one-cycle strobe: a new measurement set is on the outputs
//   locked     the set just published equals the previous one
//   err        sticky inconsistency flag, cleared only by reset
//
// Handshake: meas_vld is a pure strobe with no ready/back-pressure. It is
// high for exactly the cycle in which a freshly published set first appears
// on the measurement outputs; the outputs then hold until the next strobe.
//
// All inputs pass through one register stage, so hs/vs edges, vld and rgb
// stay cycle-aligned with each other inside the block.
module video_timing_monitor #(
  parameter int PW     = 8,
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs,
  input  logic              vs,
  input  logic              vld,
  input  logic [3*PW-1:0]   rgb,
  output logic [H_BITS-1:0] h_total,
  output logic [H_BITS-1:0] h_act,
  output logic [V_BITS-1:0] v_total,
  output logic [V_BITS-1:0] v_act,
  output logic [31:0]       frame_sum,
  output logic              meas_vld,
  output logic              locked,
  output logic              err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_TRACK   = 2'd2;

  localparam logic [H_BITS-1:0] H_ONE = {{(H_BITS-1){1'b0}}, 1'b1};
  localparam logic [V_BITS-1:0] V_ONE = {{(V_BITS-1){1'b0}}, 1'b1};

  function automatic logic [H_BITS-1:0] h_inc(input logic [H_BITS-1:0] x);
    h_inc = (x == {H_BITS{1'b1}}) ? x : x + H_ONE;
  endfunction

  function automatic logic [V_BITS-1:0] v_inc(input logic [V_BITS-1:0] x);
    v_inc = (x == {V_BITS{1'b1}}) ? x : x + V_ONE;
  endfunction

  // input stage
  logic            hs_cur_q, hs_prv_q, vs_cur_q, vs_prv_q, vld_q;
  logic [3*PW-1:0] rgb_q;

  // control and per-line counters
  logic [1:0]        state_q, state_d;
  logic [H_BITS-1:0] hcnt_q, hcnt_d;
  logic [H_BITS-1:0] pcnt_q, pcnt_d;
  logic              per_ok_q, per_ok_d;

  // per-frame accumulators
  logic [V_BITS-1:0] acc_vtot_q, acc_vtot_d;
  logic [V_BITS-1:0] acc_vact_q, acc_vact_d;
  logic [H_BITS-1:0] acc_htot_q, acc_htot_d;
  logic [H_BITS-1:0] acc_hact_q, acc_hact_d;
  logic [31:0]       acc_sum_q, acc_sum_d;
  logic [H_BITS-1:0] first_q, first_d;
  logic              first_ok_q, first_ok_d;

  // published outputs
  logic [H_BITS-1:0] h_total_q, h_total_d, h_act_q, h_act_d;
  logic [V_BITS-1:0] v_total_q, v_total_d, v_act_q, v_act_d;
  logic [31:0]       frame_sum_q, frame_sum_d;
  logic              meas_vld_q, meas_vld_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;

  // combinational helpers
  logic              hs_e, vs_e, active, start, run, frame_end, line_act;
  logic [H_BITS-1:0] period, fin_hact;
  logic [V_BITS-1:0] fin_vact, vtot_base;
  logic [H_BITS-1:0] htot_base;
  logic [31:0]       sum_base;

  always_comb begin
    hs_e      = hs_cur_q & ~hs_prv_q;
    vs_e      = vs_cur_q & ~vs_prv_q;
    active    = (state_q == S_MEASURE) || (state_q == S_TRACK);
    // The vs edge that leaves IDLE is already the first cycle of a frame.
    start     = (state_q == S_IDLE) && vs_e;
    run       = active || start;
    frame_end = active && vs_e;
    // A simultaneous hs+vs edge still closes just this one line.
    line_act  = active && (hs_e || vs_e) && (pcnt_q != '0);
    // hcnt+1 would wrap once hcnt has saturated; keep the period saturated too.
    period    = (hcnt_q == {H_BITS{1'b1}}) ? hcnt_q : hcnt_q + H_ONE;
    // Values of the frame including the line closing in this cycle.
    fin_vact  = line_act ? v_inc(acc_vact_q) : acc_vact_q;
    fin_hact  = line_act ? pcnt_q : acc_hact_q;
    // Contributions of this cycle's hs edge / pixel go to the new frame.
    vtot_base = vs_e ? '0 : acc_vtot_q;
    htot_base = vs_e ? '0 : acc_htot_q;
    sum_base  = vs_e ? '0 : acc_sum_q;
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    per_ok_d    = per_ok_q;
    acc_vtot_d  = acc_vtot_q;
    acc_vact_d  = acc_vact_q;
    acc_htot_d  = acc_htot_q;
    acc_hact_d  = acc_hact_q;
    acc_sum_d   = acc_sum_q;
    first_d     = first_q;
    first_ok_d  = first_ok_q;
    h_total_d   = h_total_q;
    h_act_d     = h_act_q;
    v_total_d   = v_total_q;
    v_act_d     = v_act_q;
    frame_sum_d = frame_sum_q;
    meas_vld_d  = 1'b0;
    locked_d    = locked_q;
    err_d       = err_q;

    if (!run) begin
      // IDLE: nothing is tracked until the first vs edge.
      hcnt_d     = '0;
      pcnt_d     = '0;
      per_ok_d   = 1'b0;
      acc_vtot_d = '0;
      acc_vact_d = '0;
      acc_htot_d = '0;
      acc_hact_d = '0;
      acc_sum_d  = '0;
      first_d    = '0;
      first_ok_d = 1'b0;
    end else begin
      hcnt_d   = hs_e ? '0 : h_inc(hcnt_q);
      // A pixel on a line-closing cycle is summed but not counted into the
      // next line, which starts counting on the following cycle.
      pcnt_d   = (hs_e || vs_e) ? '0 : (vld_q ? h_inc(pcnt_q) : pcnt_q);
      // The first hs edge only starts hcnt; later edges yield a period.
      per_ok_d = per_ok_q | hs_e;

      acc_vact_d = fin_vact;
      acc_hact_d = fin_hact;
      if (line_act && !first_ok_q) begin
        first_d    = pcnt_q;
        first_ok_d = 1'b1;
      end
      if (line_act && first_ok_q && (pcnt_q != first_q)) err_d = 1'b1;
      if (hs_e && vld_q) err_d = 1'b1;

      if (vs_e) begin
        acc_vact_d = '0;
        acc_hact_d = '0;
        first_ok_d = 1'b0;
      end
      acc_vtot_d = hs_e ? v_inc(vtot_base) : vtot_base;
      acc_htot_d = (hs_e && per_ok_q) ? period : htot_base;
      acc_sum_d  = vld_q ? sum_base + 32'(rgb_q) : sum_base;
    end

    if (frame_end) begin
      h_total_d   = acc_htot_q;
      h_act_d     = fin_hact;
      v_total_d   = acc_vtot_q;
      v_act_d     = fin_vact;
      frame_sum_d = acc_sum_q;
      meas_vld_d  = 1'b1;
      // The first publication after MEASURE has nothing valid to compare to.
      locked_d    = (state_q == S_TRACK) &&
                    (acc_htot_q == h_total_q) && (fin_hact == h_act_q) &&
                    (acc_vtot_q == v_total_q) && (fin_vact == v_act_q) &&
                    (acc_sum_q == frame_sum_q);
    end

    if (vs_e) begin
      case (state_q)
        S_IDLE:    state_d = S_MEASURE;
        S_MEASURE: state_d = S_TRACK;
        S_TRACK:   state_d = S_TRACK;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Sync history resets high so levels already high give no edge.
      hs_cur_q    <= 1'b1;
      hs_prv_q    <= 1'b1;
      vs_cur_q    <= 1'b1;
      vs_prv_q    <= 1'b1;
      vld_q       <= 1'b0;
      rgb_q       <= '0;
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      per_ok_q    <= 1'b0;
      acc_vtot_q  <= '0;
      acc_vact_q  <= '0;
      acc_htot_q  <= '0;
      acc_hact_q  <= '0;
      acc_sum_q   <= '0;
      first_q     <= '0;
      first_ok_q  <= 1'b0;
      h_total_q   <= '0;
      h_act_q     <= '0;
      v_total_q   <= '0;
      v_act_q     <= '0;
      frame_sum_q <= '0;
      meas_vld_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hs_cur_q    <= hs;
      hs_prv_q    <= hs_cur_q;
      vs_cur_q    <= vs;
      vs_prv_q    <= vs_cur_q;
      vld_q       <= vld;
      rgb_q       <= rgb;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      per_ok_q    <= per_ok_d;
      acc_vtot_q  <= acc_vtot_d;
      acc_vact_q  <= acc_vact_d;
      acc_htot_q  <= acc_htot_d;
      acc_hact_q  <= acc_hact_d;
      acc_sum_q   <= acc_sum_d;
      first_q     <= first_d;
      first_ok_q  <= first_ok_d;
      h_total_q   <= h_total_d;
      h_act_q     <= h_act_d;
      v_total_q   <= v_total_d;
      v_act_q     <= v_act_d;
      frame_sum_q <= frame_sum_d;
      meas_vld_q  <= meas_vld_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign h_total   = h_total_q;
  assign h_act     = h_act_q;
  assign v_total   = v_total_q;
  assign v_act     = v_act_q;
  assign frame_sum = frame_sum_q;
  assign meas_vld  = meas_vld_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_video_timing_monitor.sv
`timescale 1ns/1ps
module tb_video_timing_monitor;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hs, vs, vld;
  logic [23:0] rgb;
  logic [11:0] h_total, h_act, v_total, v_act;
  logic [31:0] frame_sum;
  logic        meas_vld, locked, err;

  video_timing_monitor #(.PW(8), .H_BITS(12), .V_BITS(12)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
    .h_total(h_total), .h_act(h_act), .v_total(v_total), .v_act(v_act),
    .frame_sum(frame_sum), .meas_vld(meas_vld), .locked(locked), .err(err)
  );

  logic        rst4, hs4, vs4, vld4;
  logic [23:0] rgb4;
  logic [3:0]  h_total4, h_act4;
  logic [11:0] v_total4, v_act4;
  logic [31:0] frame_sum4;
  logic        meas_vld4, locked4, err4;

  video_timing_monitor #(.PW(8), .H_BITS(4), .V_BITS(12)) dut4 (
    .clk(clk), .rst(rst4), .hs(hs4), .vs(vs4), .vld(vld4), .rgb(rgb4),
    .h_total(h_total4), .h_act(h_act4), .v_total(v_total4), .v_act(v_act4),
    .frame_sum(frame_sum4), .meas_vld(meas_vld4), .locked(locked4), .err(err4)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [11:0] ht;
    logic [11:0] ha;
    logic [11:0] vt;
    logic [11:0] va;
    logic [31:0] sum;
    logic        lk;
    logic        er;
  } pub_t;

  pub_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a frame is described by line length, line count,
  // pixel offset, per-line pixel counts and a pixel colour.
  int          fr_L, fr_N, fr_off;
  int          fr_cnt[16];
  int          base_cnt[16];
  logic [23:0] fr_c;
  pub_t        pend, last_pub;
  bit          pend_ok, pend_bad, err_sticky;
  int          pub_idx;

  function automatic void model_clear();
    pend_ok    = 1'b0;
    pend_bad   = 1'b0;
    err_sticky = 1'b0;
    pub_idx    = 0;
    pend       = '0;
    last_pub   = '0;
  endfunction

  // Called as a frame begins: its vs publishes the previous frame.
  function automatic void model_frame_begin();
    int          first, va, ha;
    int unsigned s;
    if (pend_ok) begin
      err_sticky = err_sticky | pend_bad;
      pend.er = err_sticky;
      pend.lk = (pub_idx > 0) && (pend.ht == last_pub.ht) && (pend.ha == last_pub.ha) &&
                (pend.vt == last_pub.vt) && (pend.va == last_pub.va) && (pend.sum == last_pub.sum);
      exp_q.push_back(pend);
      last_pub = pend;
      pub_idx++;
    end
    first = -1; va = 0; ha = 0; s = 0; pend_bad = 1'b0;
    for (int n = 0; n < fr_N; n++) begin
      s += fr_cnt[n] * fr_c;
      if (fr_cnt[n] > 0) begin
        va++;
        ha = fr_cnt[n];
        if (first < 0) first = fr_cnt[n];
        else if (fr_cnt[n] != first) pend_bad = 1'b1;
      end
    end
    pend     = '0;
    pend.ht  = 12'(fr_L);
    pend.vt  = 12'(fr_N);
    pend.va  = 12'(va);
    pend.ha  = 12'(ha);
    pend.sum = s;
    pend_ok  = 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic drive_frame();
    logic d;
    model_frame_begin();
    for (int n = 0; n < fr_N; n++) begin
      for (int t = 0; t < fr_L; t++) begin
        d   = (t >= fr_off) && (t < fr_off + fr_cnt[n]);
        hs  = (t == 0);
        vs  = (t == 0) && (n == 0);
        vld = d;
        rgb = d ? fr_c : 24'($urandom);
        cyc(1);
      end
    end
    hs = 1'b0; vs = 1'b0; vld = 1'b0;
  endtask

  task automatic set_std(input bit short5);
    fr_L = 20; fr_N = 10; fr_off = 4; fr_c = 24'h010203;
    for (int n = 0; n < 16; n++) fr_cnt[n] = (n >= 3 && n <= 6) ? 8 : 0;
    if (short5) fr_cnt[5] = 7;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      cyc(1);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d publications outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_total"}, 32'(h_total), 32'd0);
    check({tag, "_h_act"}, 32'(h_act), 32'd0);
    check({tag, "_v_total"}, 32'(v_total), 32'd0);
    check({tag, "_v_act"}, 32'(v_act), 32'd0);
    check({tag, "_frame_sum"}, frame_sum, 32'd0);
    check({tag, "_meas_vld"}, 32'(meas_vld), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // ---------------- monitor ----------------
  pub_t got, want, hold_ref;
  logic prev_mv = 1'b0;
  int   pub_seen = 0;

  always @(negedge clk) begin
    got = {h_total, h_act, v_total, v_act, frame_sum, locked, err};
    if (rst) begin
      hold_ref = '0;
      prev_mv  = 1'b0;
    end else if (meas_vld) begin
      n_tests++;
      if (prev_mv) begin
        n_fail++;
        $display("FAIL meas_vld_width: high on consecutive cycles, expected one-cycle pulse");
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_meas_vld: strobe with no publication expected");
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL pub%0d: got ht=%0d ha=%0d vt=%0d va=%0d sum=%08h lk=%0b er=%0b, expected ht=%0d ha=%0d vt=%0d va=%0d sum=%08h lk=%0b er=%0b",
                   pub_seen, got.ht, got.ha, got.vt, got.va, got.sum, got.lk, got.er,
                   want.ht, want.ha, want.vt, want.va, want.sum, want.lk, want.er);
        end
      end
      pub_seen++;
      hold_ref = got;
      prev_mv  = 1'b1;
    end else begin
      n_tests++;
      if ({got.ht, got.ha, got.vt, got.va, got.sum, got.lk} !==
          {hold_ref.ht, hold_ref.ha, hold_ref.vt, hold_ref.va, hold_ref.sum, hold_ref.lk}) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL hold: outputs changed without meas_vld, got sum=%08h expected %08h",
                   got.sum, hold_ref.sum);
        hold_ref = got;
      end
      prev_mv = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, reps, u, pick;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0;
    rst4 = 1'b1; hs4 = 1'b0; vs4 = 1'b0; vld4 = 1'b0; rgb4 = '0;
    model_clear();
    cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    cyc(5);

    // Standard stream, then a frame with a short line 5, then clean frames.
    set_std(1'b0);
    repeat (3) drive_frame();
    set_std(1'b1);
    drive_frame();
    set_std(1'b0);
    repeat (3) drive_frame();
    wait_drain();
    check("err_sticky_live", 32'(err), 32'd1);

    // Mid-frame reset with hs/vs held high through release.
    hs = 1'b1; vs = 1'b1; vld = 1'b0; rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check_all_zero("midrst");
    hs = 1'b0; vs = 1'b0;
    cyc(5);
    model_clear();
    set_std(1'b0);
    repeat (3) drive_frame();
    wait_drain();

    // Randomized frames, each template repeated to exercise locked.
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    model_clear();
    for (int tpl = 0; tpl < 10; tpl++) begin
      fr_L   = $urandom_range(12, 40);
      fr_N   = $urandom_range(2, 12);
      fr_off = $urandom_range(1, 3);
      fr_c   = 24'($urandom);
      u      = $urandom_range(1, fr_L - fr_off - 1);
      for (int n = 0; n < 16; n++) base_cnt[n] = ($urandom_range(0, 3) == 0) ? 0 : u;
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        for (int n = 0; n < 16; n++) fr_cnt[n] = base_cnt[n];
        if ($urandom_range(0, 4) == 0) begin
          pick = $urandom_range(0, fr_N - 1);
          if (fr_cnt[pick] > 0) fr_cnt[pick] = (u > 1) ? u - 1 : u + 1;
        end
        drive_frame();
      end
    end
    set_std(1'b0);
    drive_frame();
    wait_drain();

    // Narrow instance: hs and vld stuck high, pixel counter must saturate.
    rst4 = 1'b1;
    cyc(2);
    rst4 = 1'b0;
    cyc(3);
    vs4 = 1'b1;
    cyc(1);
    vs4 = 1'b0;
    cyc(3);
    hs4 = 1'b1; vld4 = 1'b1; rgb4 = 24'h0a0b0c;
    cyc(40);
    check("sat_err_live", 32'(err4), 32'd1);
    vs4 = 1'b1;
    cyc(1);
    vs4 = 1'b0;
    k = 0;
    while (!meas_vld4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (!meas_vld4) begin
      n_fail++;
      $display("FAIL sat_meas_vld: no strobe within 20 cycles, expected one");
    end else begin
      check("sat_h_act", 32'(h_act4), 32'd15);
      check("sat_v_act", 32'(v_act4), 32'd1);
      check("sat_v_total", 32'(v_total4), 32'd1);
      check("sat_h_total", 32'(h_total4), 32'd0);
      check("sat_frame_sum", frame_sum4, 32'd40 * 32'h000a0b0c);
      check("sat_locked", 32'(locked4), 32'd0);
      check("sat_err", 32'(err4), 32'd1);
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
